// File: rtl/inst_buffer_pkg.sv
// Shared widths, control levels and the entry record for the fetch-to-decode
// instruction buffer.
package inst_buffer_pkg;

   localparam int InstAddrBusW = 32;
   localparam int InstBusW     = 32;

   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic        FlushEnable = 1'b1;
   localparam logic        Stop        = 1'b1;

   // One buffered instruction: fetch PC, instruction word, address-error flag.
   typedef struct packed {
      logic [InstAddrBusW-1:0] pc;
      logic [InstBusW-1:0]     inst;
      logic                    adel;
   } ib_entry_t;

   localparam int EntryW = $bits(ib_entry_t);

   function automatic ib_entry_t make_entry(
      input logic [InstAddrBusW-1:0] pc,
      input logic [InstBusW-1:0]     inst,
      input logic                    adel
   );
      ib_entry_t e;
      e.pc   = pc;
      e.inst = inst;
      e.adel = adel;
      return e;
   endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/decode side signals of the instruction buffer. The slave modport is
// the buffer itself; the master modport is the surrounding pipeline.
interface inst_buffer_if;
   import inst_buffer_pkg::*;

   logic                    flush;
   logic                    stall;
   logic                    if_valid;
   logic [InstAddrBusW-1:0] if_pc;
   logic [InstBusW-1:0]     if_inst;
   logic                    if_adel;
   logic                    buf_full;
   logic                    id_valid;
   logic [InstAddrBusW-1:0] id_pc;
   logic [InstBusW-1:0]     id_inst;
   logic                    id_adel;

   modport slave (
      input  flush, stall, if_valid, if_pc, if_inst, if_adel,
      output buf_full, id_valid, id_pc, id_inst, id_adel
   );

   modport master (
      output flush, stall, if_valid, if_pc, if_inst, if_adel,
      input  buf_full, id_valid, id_pc, id_inst, id_adel
   );

endinterface

// File: rtl/inst_buffer_mem.sv
// Entry storage for the instruction buffer: one write port, one asynchronous
// read port. Contents are deliberately not reset; validity lives in the count.
module inst_buffer_mem
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  ib_entry_t        wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output ib_entry_t        rd_data
);

   ib_entry_t mem_reg [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/inst_buffer.sv
// Circular FIFO between fetch and decode. Pointers and occupancy count live
// here; entry storage is in inst_buffer_mem.
module inst_buffer
   import inst_buffer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   inst_buffer_if.slave  bus
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;

   logic      full;
   logic      not_empty;
   logic      flush_req;
   logic      hold;
   logic      push;
   logic      pop;
   ib_entry_t wr_entry;
   ib_entry_t head_entry;

   // Full/empty come only from the registered count, so buf_full never
   // depends combinationally on this cycle's pop.
   assign full      = (count_reg == FULL_CNT);
   assign not_empty = (count_reg != '0);
   assign flush_req = (bus.flush == FlushEnable);
   assign hold      = (bus.stall == Stop);

   assign push = bus.if_valid && !full && !flush_req;
   assign pop  = not_empty && !hold && !flush_req;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush_req) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (push) begin
            tail_next = tail_reg + PTR_W'(1);
         end
         if (pop) begin
            head_next = head_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign wr_entry = make_entry(bus.if_pc, bus.if_inst, bus.if_adel);

   inst_buffer_mem #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (tail_reg),
      .wr_data (wr_entry),
      .rd_addr (head_reg),
      .rd_data (head_entry)
   );

   // Stale storage must never leak to decode: outputs read zero when empty.
   assign bus.buf_full = full;
   assign bus.id_valid = not_empty;
   assign bus.id_pc    = not_empty ? head_entry.pc   : ZeroWord;
   assign bus.id_inst  = not_empty ? head_entry.inst : ZeroWord;
   assign bus.id_adel  = not_empty ? head_entry.adel : 1'b0;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: a vector table for single-cycle behaviour
// plus queue-checked sequences for fill, drain, full-with-pop and wrap.
module tb_inst_buffer;
   import inst_buffer_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   inst_buffer_if bus();

   inst_buffer #(
      .DEPTH (8),
      .CNT_W (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        rst, flush, stall, vld;
      logic [31:0] pc, inst;
      logic        adel;
      logic        e_full, e_valid;
      logic [31:0] e_pc, e_inst;
      logic        e_adel;
   } vec_t;

   vec_t      vecs[21];
   ib_entry_t model_q[$];

   function automatic vec_t mk(
      input logic r, input logic f, input logic s, input logic v,
      input logic [31:0] pc, input logic [31:0] inst, input logic a,
      input logic ef, input logic ev,
      input logic [31:0] epc, input logic [31:0] einst, input logic ea
   );
      vec_t t;
      t.rst = r; t.flush = f; t.stall = s; t.vld = v;
      t.pc = pc; t.inst = inst; t.adel = a;
      t.e_full = ef; t.e_valid = ev; t.e_pc = epc; t.e_inst = einst; t.e_adel = ea;
      return t;
   endfunction

   function automatic logic [66:0] obs();
      return {bus.buf_full, bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst};
   endfunction

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got full/valid/adel/pc/inst=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic f, input logic s, input logic v,
                        input logic [31:0] pc, input logic [31:0] inst, input logic a);
      rst = r; bus.flush = f; bus.stall = s; bus.if_valid = v;
      bus.if_pc = pc; bus.if_inst = inst; bus.if_adel = a;
      @(posedge clk);
      #1;
      $display("txn rst=%b flush=%b stall=%b push=%b pc=%h -> full=%b valid=%b id_pc=%h adel=%b",
               r, f, s, v, pc, bus.buf_full, bus.id_valid, bus.id_pc, bus.id_adel);
   endtask

   // Reference behaviour as an ordinary queue: refuses pushes at 8 entries
   // judged on the occupancy before this cycle's pop.
   task automatic step(input string name, input logic r, input logic f, input logic s,
                       input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic a);
      int          n;
      ib_entry_t   e;
      logic [66:0] exp;
      apply(r, f, s, v, pc, inst, a);
      if (r || f) begin
         model_q.delete();
      end else begin
         n = model_q.size();
         if (n != 0 && !s) void'(model_q.pop_front());
         if (v && n < 8) begin
            e.pc = pc; e.inst = inst; e.adel = a;
            model_q.push_back(e);
         end
      end
      if (model_q.size() == 0) exp = '0;
      else exp = {model_q.size() == 8, 1'b1, model_q[0].adel, model_q[0].pc, model_q[0].inst};
      chk(name, obs(), exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0; bus.if_valid = 1'b0;
      bus.if_pc = '0; bus.if_inst = '0; bus.if_adel = 1'b0;

      vecs[0]  = mk(1,0,0,0, 32'h0,        32'h0,        0, 0,0, 32'h0,        32'h0,        0);
      vecs[1]  = mk(0,0,1,1, 32'hBFC00000, 32'h24080001, 0, 0,1, 32'hBFC00000, 32'h24080001, 0);
      vecs[2]  = mk(0,0,1,0, 32'h0,        32'h0,        0, 0,1, 32'hBFC00000, 32'h24080001, 0);
      vecs[3]  = mk(0,0,0,0, 32'h0,        32'h0,        0, 0,0, 32'h0,        32'h0,        0);
      vecs[4]  = mk(0,0,1,1, 32'h00000003, 32'h11111111, 1, 0,1, 32'h00000003, 32'h11111111, 1);
      vecs[5]  = mk(0,0,0,1, 32'h00000008, 32'h22222222, 0, 0,1, 32'h00000008, 32'h22222222, 0);
      vecs[6]  = mk(0,0,0,0, 32'h0,        32'h0,        0, 0,0, 32'h0,        32'h0,        0);
      vecs[7]  = mk(0,0,1,1, 32'h00000100, 32'hAAAA0100, 0, 0,1, 32'h00000100, 32'hAAAA0100, 0);
      vecs[8]  = mk(0,0,1,1, 32'h00000104, 32'hAAAA0104, 0, 0,1, 32'h00000100, 32'hAAAA0100, 0);
      vecs[9]  = mk(0,0,1,1, 32'h00000108, 32'hAAAA0108, 0, 0,1, 32'h00000100, 32'hAAAA0100, 0);
      vecs[10] = mk(0,0,1,1, 32'h0000010C, 32'hAAAA010C, 0, 0,1, 32'h00000100, 32'hAAAA0100, 0);
      vecs[11] = mk(0,0,1,1, 32'h00000110, 32'hAAAA0110, 0, 0,1, 32'h00000100, 32'hAAAA0100, 0);
      vecs[12] = mk(0,1,1,1, 32'h00000200, 32'hBBBB0200, 0, 0,0, 32'h0,        32'h0,        0);
      vecs[13] = mk(0,0,1,1, 32'h00000300, 32'hCCCC0300, 0, 0,1, 32'h00000300, 32'hCCCC0300, 0);
      vecs[14] = mk(0,0,1,1, 32'h00000304, 32'hCCCC0304, 0, 0,1, 32'h00000300, 32'hCCCC0300, 0);
      vecs[15] = mk(0,0,1,1, 32'h00000308, 32'hCCCC0308, 0, 0,1, 32'h00000300, 32'hCCCC0300, 0);
      vecs[16] = mk(0,0,1,1, 32'h0000030C, 32'hCCCC030C, 0, 0,1, 32'h00000300, 32'hCCCC0300, 0);
      vecs[17] = mk(1,0,1,1, 32'h00000400, 32'hDDDD0400, 1, 0,0, 32'h0,        32'h0,        0);
      vecs[18] = mk(0,0,0,0, 32'h0,        32'h0,        0, 0,0, 32'h0,        32'h0,        0);
      vecs[19] = mk(0,0,1,1, 32'h00000500, 32'hEEEE0500, 0, 0,1, 32'h00000500, 32'hEEEE0500, 0);
      vecs[20] = mk(1,1,0,1, 32'h00000504, 32'hEEEE0504, 0, 0,0, 32'h0,        32'h0,        0);

      for (int i = 0; i < 21; i++) begin
         apply(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].vld,
               vecs[i].pc, vecs[i].inst, vecs[i].adel);
         chk($sformatf("vec%0d", i), obs(),
             {vecs[i].e_full, vecs[i].e_valid, vecs[i].e_adel, vecs[i].e_pc, vecs[i].e_inst});
      end

      // Fill to full under stall, drop a 9th push, then drain in order.
      step("fill_rst", 1, 0, 0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 8; i++)
         step($sformatf("fill%0d", i), 0, 0, 1, 1, 32'(4 * i), 32'h0C000000 + 32'(i), 0);
      chk("full_after_8th", 67'(bus.buf_full), 67'(1));
      step("push9_dropped", 0, 0, 1, 1, 32'h00000020, 32'h0C0000FF, 0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_head%0d", i), 67'(bus.id_pc), 67'(32'(4 * i)));
         step($sformatf("drain%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 0);
      end
      chk("drain_empty", 67'(bus.id_valid), 67'(0));

      // Full buffer with simultaneous push and pop: push refused, then accepted.
      step("wrap_rst", 1, 0, 0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 8; i++)
         step($sformatf("wfill%0d", i), 0, 0, 1, 1, 32'h40 + 32'(4 * i), 32'h5000_0000 + 32'(i), 0);
      step("full_pushpop", 0, 0, 0, 1, 32'h000000E0, 32'h500000E0, 0);
      chk("full_pushpop_notfull", 67'(bus.buf_full), 67'(0));
      step("refill", 0, 0, 1, 1, 32'h000000E4, 32'h500000E4, 0);
      chk("refill_full", 67'(bus.buf_full), 67'(1));
      for (int i = 0; i < 4; i++)
         step($sformatf("partial_drain%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 0);
      for (int i = 0; i < 20; i++)
         step($sformatf("stream%0d", i), 0, 0, 0, 1, 32'h1000 + 32'(4 * i), 32'h6000_0000 + 32'(i), i[0]);
      for (int i = 0; i < 5; i++)
         step($sformatf("final_drain%0d", i), 0, 0, 0, 0, 32'h0, 32'h0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of buffer entries; power of two, >= 2.
REQ-002 SHALL have parameter CNT_W, default 4, count width (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush from ctrl (exception/ERET redirect).
REQ-006 SHALL have port stall  input  1  stall[0] from ctrl; 1 = decode holds, no pop.
REQ-007 SHALL have port if_valid  input  1  fetch presents an instruction this cycle.
REQ-008 SHALL have port if_pc  input  32  fetch PC.
REQ-009 SHALL have port if_inst  input  32  fetched instruction word.
REQ-010 SHALL have port if_adel  input  1  fetch address-error flag travelling with the instruction.
REQ-011 SHALL have port buf_full  output  1  1 = no push accepted this cycle.
REQ-012 SHALL have port id_valid  output  1  head entry valid for decode.
REQ-013 SHALL have port id_pc  output  32  head PC.
REQ-014 SHALL have port id_inst  output  32  head instruction.
REQ-015 SHALL have port id_adel  output  1  head address-error flag.

Function
REQ-016 SHALL store {pc, inst, adel} entries in FIFO order in a circular array indexed by head/tail pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL keep occupancy count (CNT_W bits, range 0..DEPTH); buf_full = (count == DEPTH), derived from registered count only.
REQ-018 SHALL accept a push when if_valid=1 and buf_full=0 and flush=0; a push while full SHALL be dropped with no state change (fetch must respect buf_full).
REQ-019 SHALL pop the head when id_valid=1 and stall=0 and flush=0.
REQ-020 SHALL make a pushed entry visible on id_* no earlier than the cycle after the push (no same-cycle bypass); empty-buffer latency = 1 cycle.
REQ-021 SHALL present id_valid = (count != 0); id_pc/id_inst = 32'h0 and id_adel = 0 when count == 0.
REQ-022 SHALL hold id_* stable for as long as stall=1 and id_valid=1.
REQ-023 SHALL handle simultaneous push and pop: count unchanged, both pointers advance; when full, push still refused even if a pop occurs that cycle.
REQ-024 SHALL, on flush=1, clear count and both pointers the next cycle, discarding all entries and any same-cycle push; flush overrides stall.
REQ-025 SHALL give priority rst > flush > push/pop.
REQ-026 SHALL never let count exceed DEPTH or underflow below 0.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set count=0, head=0, tail=0; hence id_valid=0, id_pc=0, id_inst=0, id_adel=0, buf_full=0 the following cycle.
REQ-028 SHALL, on reset mid-operation, discard all entries regardless of stall, flush or if_valid; storage array contents need not be reset.

Structure
REQ-029 SHALL take ZeroWord, InstBus/InstAddrBus widths, FlushEnable and Stop levels from the shared defines.v package; DEPTH stays a local parameter.
REQ-030 SHALL implement the storage as one sub-module, inst_buffer_mem (1 write port, 1 async read port, DEPTH x 65 bits); pointer/count logic stays in inst_buffer.

Verification
REQ-031 SHALL cover: reset, push pc=0xBFC00000 inst=0x24080001 -> next cycle id_valid=1, id_pc=0xBFC00000; stall=0 pops -> id_valid=0 after pop.
REQ-032 SHALL cover: 8 pushes, stall=1 -> buf_full=1 after 8th; 9th push (pc=0x20) dropped; release stall -> pops return pc 0x00..0x1C in order, then id_valid=0.
REQ-033 SHALL cover: full buffer, simultaneous push and pop -> push refused, count 7; next cycle push accepted, count 8; pointer wrap verified over 20 entries in order.
REQ-034 SHALL cover: 5 entries, flush=1 with if_valid=1 and stall=1 -> next cycle id_valid=0, buf_full=0; next push appears as head.
REQ-035 SHALL cover: if_adel=1 with pc=0x00000003 -> id_adel=1 with that entry only; rst=1 asserted mid-stream with 4 entries -> all outputs 0 next cycle.
